// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data memory responder: FSM encoding,
// default geometry/latency and the latency counter width.
package dmem_pkg;
   localparam int DEF_DEPTH_WORDS = 1024;
   localparam int DEF_LATENCY     = 2;
   localparam int CNT_W           = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;
endpackage

// File: rtl/dmem_byte_ram.sv
// Word-addressed storage built from four independent byte lanes:
// synchronous per-lane write, combinational read of the addressed word.
module dmem_byte_ram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic [3:0]    lane_we,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   for (genvar g = 0; g < 4; g++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
         if (lane_we[g]) mem[idx] <= wdata[8*g +: 8];
      end

      assign rdata[8*g +: 8] = mem[idx];
   end
endmodule

// File: rtl/data_memory_responder.sv
// Fixed-latency data memory slave: captures one load/store request, waits
// LATENCY cycles, then strobes Ack and commits any byte-masked write.
module data_memory_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
   parameter int LATENCY     = DEF_LATENCY
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        ReadEnable,
   input  logic        WriteEnable,
   input  logic [3:0]  ByteEnable,
   output logic [31:0] ReadData,
   output logic        Ack
);
   localparam int AW = $clog2(DEPTH_WORDS);

   dmem_state_t state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             accept;

   logic [AW-1:0] cap_idx;
   logic [31:0]   cap_wdata;
   logic [3:0]    cap_be;
   logic          cap_re, cap_we;

   logic [31:0] ram_rdata, merged, rdata_q;
   logic [3:0]  lane_we;
   logic        in_resp;

   // Byte offset and bits above the array size do not select storage.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{Address[31:AW+2], Address[1:0]};

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (ReadEnable | WriteEnable) begin
               accept     = 1'b1;
               cnt_next   = CNT_W'(LATENCY - 1);
               state_next = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_next = cnt - 1'b1;
            if (cnt == CNT_W'(1)) state_next = RESP;
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         cnt     <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (in_resp && cap_re) rdata_q <= merged;
      end
   end

   always_ff @(posedge CLK) begin
      if (accept && !RST) begin
         cap_idx   <= Address[AW+1:2];
         cap_wdata <= WriteData;
         cap_be    <= ByteEnable;
         cap_re    <= ReadEnable;
         cap_we    <= WriteEnable;
      end
   end

   assign in_resp = (state == RESP);

   // Post-write view of the word, so a combined read+write returns merged data.
   always_comb begin
      merged = ram_rdata;
      for (int i = 0; i < 4; i++) begin
         if (cap_we && cap_be[i]) merged[8*i +: 8] = cap_wdata[8*i +: 8];
      end
   end

   assign lane_we  = {4{in_resp && cap_we && !RST}} & cap_be;
   assign Ack      = in_resp;
   assign ReadData = (in_resp && cap_re) ? merged : rdata_q;

   dmem_byte_ram #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .AW         (AW)
   ) u_ram (
      .clk    (CLK),
      .lane_we(lane_we),
      .idx    (cap_idx),
      .wdata  (cap_wdata),
      .rdata  (ram_rdata)
   );
endmodule
